// File: rtl/div16_repsub_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
package div16_repsub_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned STATE_W   = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t LOAD_A = 3'd1;
  localparam state_t LOAD_B = 3'd2;
  localparam state_t SUB    = 3'd3;
  localparam state_t DONE   = 3'd4;

  // Controller-to-datapath strobes
  typedef struct packed {
    logic ld_a;
    logic ld_b;
    logic ld_r;
    logic clr_q;
    logic set_q;
    logic sub_r;
    logic inc_q;
  } dp_ctrl_t;

endpackage

// File: rtl/div16_repsub_datapath.sv
// Operand, quotient and remainder registers with subtract/increment/compare logic.
module div_datapath
  import div16_repsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  dp_ctrl_t         ctrl,
  input  logic [WIDTH-1:0] data_in,
  output logic             ge_b,
  output logic             eqz_b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      q_q <= '0;
      r_q <= '0;
    end else begin
      if (ctrl.ld_a) a_q <= data_in;
      if (ctrl.ld_b) b_q <= data_in;
      // Subtraction is only strobed when r_q >= b_q, so it cannot wrap
      if (ctrl.ld_r)       r_q <= a_q;
      else if (ctrl.sub_r) r_q <= r_q - b_q;
      if (ctrl.clr_q)      q_q <= '0;
      else if (ctrl.set_q) q_q <= '1;
      else if (ctrl.inc_q) q_q <= q_q + WIDTH'(1);
    end
  end

  assign ge_b      = (r_q >= b_q);
  assign eqz_b     = (data_in == '0);
  assign quotient  = q_q;
  assign remainder = r_q;

endmodule

// File: rtl/div16_repsub.sv
// Unsigned divider by repeated subtraction: controller FSM plus div_datapath.
module div16_repsub
  import div16_repsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  state_t   state;
  state_t   state_next;
  dp_ctrl_t ctrl;
  logic     ge_b;
  logic     eqz_b;
  logic     busy_next;
  logic     done_next;
  logic     dz_next;

  // State register; status outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_next;
      busy        <= busy_next;
      done        <= done_next;
      div_by_zero <= dz_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD_A;
      LOAD_A:  state_next = LOAD_B;
      LOAD_B:  state_next = eqz_b ? DONE : SUB;
      SUB:     if (!ge_b) state_next = DONE;
      DONE:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath strobes and next values of the status outputs
  always_comb begin
    ctrl      = '0;
    busy_next = 1'b0;
    done_next = 1'b0;
    dz_next   = 1'b0;
    case (state)
      LOAD_A: ctrl.ld_a = 1'b1;
      LOAD_B: begin
        ctrl.ld_b  = 1'b1;
        ctrl.ld_r  = 1'b1;
        ctrl.set_q = eqz_b;
        ctrl.clr_q = !eqz_b;
      end
      SUB: begin
        ctrl.sub_r = ge_b;
        ctrl.inc_q = ge_b;
      end
      default: ;
    endcase
    busy_next = (state_next == LOAD_A) || (state_next == LOAD_B) || (state_next == SUB);
    done_next = (state_next == DONE);
    // The zero-divisor flag is captured on LOAD_B exit and held through DONE
    dz_next   = done_next && ((state == LOAD_B) ? eqz_b : div_by_zero);
  end

  div_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .ctrl      (ctrl),
    .data_in   (data_in),
    .ge_b      (ge_b),
    .eqz_b     (eqz_b),
    .quotient  (quotient),
    .remainder (remainder)
  );

endmodule

// File: tb/tb_div16_repsub.sv
// Directed table-driven bench for div16_repsub plus handshake and reset sequences.
module tb_div16_repsub;

  localparam int unsigned W = 16;
  localparam int MAX_EDGES = 70000;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] data_in;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dz;
    int           exp_lat;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  div16_repsub dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Launch one operation; returns edges from the start-sampling edge until done is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic keep_start,
                        output int lat, output bit busy_ok);
    int edges;
    busy_ok = 1'b1;
    lat     = -1;
    @(negedge clk); start = 1'b1; data_in = '0;
    @(posedge clk);
    @(negedge clk); start = keep_start; data_in = a;
    if (!busy || done) busy_ok = 1'b0;
    @(posedge clk);
    edges = 1;
    @(negedge clk); data_in = b;
    if (!busy || done) busy_ok = 1'b0;
    while (edges < MAX_EDGES) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done) begin
        lat = edges;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: done not seen within %0d edges", MAX_EDGES);
    end
  endtask

  task automatic release_start();
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int  lat;
    bit  bok;

    vecs[0] = '{16'd17,    16'd5,     16'd3,      16'd2,   1'b0, 6};
    vecs[1] = '{16'd5,     16'd17,    16'd0,      16'd5,   1'b0, 3};
    vecs[2] = '{16'd0,     16'd7,     16'd0,      16'd0,   1'b0, 3};
    vecs[3] = '{16'd9,     16'd9,     16'd1,      16'd0,   1'b0, 4};
    vecs[4] = '{16'd100,   16'd0,     16'hFFFF,   16'd100, 1'b1, 2};
    vecs[5] = '{16'd1000,  16'd3,     16'd333,    16'd1,   1'b0, 336};
    vecs[6] = '{16'd65535, 16'd65535, 16'd1,      16'd0,   1'b0, 4};
    vecs[7] = '{16'd12345, 16'd256,   16'd48,     16'd57,  1'b0, 51};
    vecs[8] = '{16'd65535, 16'd1,     16'hFFFF,   16'd0,   1'b0, 65538};

    rst = 1'b1; start = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_dz",   32'(div_by_zero), 32'd0);
    chk("reset_q",    32'(quotient), 32'd0);
    chk("reset_r",    32'(remainder), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0, lat, bok);
      if (lat >= 0) begin
        chk($sformatf("v%0d_q", i),    32'(quotient),    32'(vecs[i].exp_q));
        chk($sformatf("v%0d_r", i),    32'(remainder),   32'(vecs[i].exp_r));
        chk($sformatf("v%0d_dz", i),   32'(div_by_zero), 32'(vecs[i].exp_dz));
        chk($sformatf("v%0d_lat", i),  32'(lat),         32'(vecs[i].exp_lat));
        chk($sformatf("v%0d_busy", i), 32'(bok),         32'd1);
        chk($sformatf("v%0d_busy_done", i), 32'(busy),   32'd0);
      end
      release_start();
      chk($sformatf("v%0d_idle_done", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_idle_dz", i),   32'(div_by_zero), 32'd0);
    end

    // start held high: one operation, DONE persists until start drops
    run_op(16'd12, 16'd4, 1'b1, lat, bok);
    chk("hold_lat", 32'(lat), 32'd6);
    chk("hold_q",   32'(quotient), 32'd3);
    chk("hold_r",   32'(remainder), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold_done_%0d", k), 32'(done), 32'd1);
      chk($sformatf("hold_busy_%0d", k), 32'(busy), 32'd0);
    end
    release_start();
    chk("hold_release_done", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("hold_idle_busy", 32'(busy), 32'd0);
    run_op(16'd50, 16'd7, 1'b0, lat, bok);
    chk("after_hold_q", 32'(quotient), 32'd7);
    chk("after_hold_r", 32'(remainder), 32'd1);
    release_start();

    // Reset ten cycles into SUB abandons the operation
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; data_in = 16'd1000;
    @(posedge clk);
    @(negedge clk); data_in = 16'd3;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midsub_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midsub_busy", 32'(busy), 32'd0);
    chk("midsub_done", 32'(done), 32'd0);
    chk("midsub_q",    32'(quotient), 32'd0);
    chk("midsub_r",    32'(remainder), 32'd0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("midsub_stay_idle", 32'(busy | done), 32'd0);
    end
    run_op(16'd20, 16'd6, 1'b0, lat, bok);
    chk("post_reset_q",   32'(quotient), 32'd3);
    chk("post_reset_r",   32'(remainder), 32'd2);
    chk("post_reset_lat", 32'(lat), 32'd6);
    release_start();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
